// File: rtl/red_pkg.sv
// Shared encodings for the bit-serial comparison network.
// XY state codes and FSM states used by cell and top.
package red_pkg;

    localparam logic [1:0] XY_EQ  = 2'b00;
    localparam logic [1:0] XY_AGT = 2'b10;
    localparam logic [1:0] XY_ALT = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/celda_der_izq_c.sv
// One comparison cell: a differing bit overrides the carried XY,
// an equal bit passes the carried XY through unchanged.
module celda_der_izq_c
    import red_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic x_in,
    input  logic y_in,
    output logic x_out,
    output logic y_out
);

    // Later (more significant) differences overwrite earlier ones
    always_comb begin
        {x_out, y_out} = {x_in, y_in};
        if (a != b) begin
            {x_out, y_out} = a ? XY_AGT : XY_ALT;
        end
    end

endmodule

// File: rtl/red_serial_der_izq_c.sv
// Bit-serial magnitude comparator, LSB first, one bit per clock.
// Z = ~X after N bits; Z_out mirrors Z as the active-low line.
module red_serial_der_izq_c
    import red_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic         X,
    output logic         Y,
    output logic         Z,
    output logic         Z_out
);

    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     sa;
    logic [N-1:0]     sb;
    logic             x_q;
    logic             y_q;
    logic             z_q;
    logic             x_nx;
    logic             y_nx;

    celda_der_izq_c u_celda (
        .a     (sa[0]),
        .b     (sb[0]),
        .x_in  (x_q),
        .y_in  (y_q),
        .x_out (x_nx),
        .y_out (y_nx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: if (start)       state_n = ST_SCAN;
            ST_SCAN: if (cnt == LAST) state_n = ST_DONE;
            ST_DONE:                  state_n = ST_IDLE;
            default:                  state_n = ST_IDLE;
        endcase
    end

    // Operand shifters, bit counter and XY/Z result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            sa  <= '0;
            sb  <= '0;
            x_q <= 1'b0;
            y_q <= 1'b0;
            z_q <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sa  <= A;
                        sb  <= B;
                        x_q <= 1'b0;
                        y_q <= 1'b0;
                        cnt <= '0;
                    end
                end
                ST_SCAN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    x_q <= x_nx;
                    y_q <= y_nx;
                    if (cnt == LAST) z_q <= ~x_nx;
                    else             cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ready = (state == ST_IDLE);
    assign busy  = (state == ST_SCAN) || (state == ST_DONE);
    assign done  = (state == ST_DONE);
    assign X     = x_q;
    assign Y     = y_q;
    assign Z     = z_q;
    assign Z_out = z_q;

endmodule

// File: tb/tb_red_serial_der_izq_c.sv
// Directed + random checks of the serial comparator against an
// arithmetic model (masked unsigned compare of the bits seen so far).
module tb_red_serial_der_izq_c;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         ready;
    logic         busy;
    logic         done;
    logic         X;
    logic         Y;
    logic         Z;
    logic         Z_out;

    int n_assert = 0;
    int n_fail   = 0;
    logic z_prev;

    red_serial_der_izq_c #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .X     (X),
        .Y     (Y),
        .Z     (Z),
        .Z_out (Z_out)
    );

    always #5 clk = ~clk;

    // XY after bits 0..k: compare the low k+1 bits as unsigned numbers
    function automatic logic [1:0] xy_ref(input logic [N-1:0] a,
                                          input logic [N-1:0] b,
                                          input int k);
        int unsigned m;
        int unsigned am;
        int unsigned bm;
        m  = (32'd1 << (k + 1)) - 32'd1;
        am = 32'(a) & m;
        bm = 32'(b) & m;
        if (am > bm)      return 2'b10;
        else if (am < bm) return 2'b01;
        else              return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full transaction; hold=1 keeps start high and corrupts A/B
    task automatic op(input logic [N-1:0] a, input logic [N-1:0] b,
                      input bit hold);
        logic [1:0] e;
        e = 2'b00;
        @(negedge clk);
        chk("ready_pre", ready, 1'b1);
        start = 1'b1;
        A = a;
        B = b;
        @(negedge clk);
        chk("busy_acc", busy, 1'b1);
        chk("ready_acc", ready, 1'b0);
        chk("x_clr", X, 1'b0);
        chk("y_clr", Y, 1'b0);
        chk("z_keep", Z, z_prev);
        if (hold) begin
            A = 8'hFF;
            B = 8'h00;
        end else begin
            start = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            e = xy_ref(a, b, i);
            chk("x_step", X, e[1]);
            chk("y_step", Y, e[0]);
            chk("zout_eq", Z_out, Z);
            if (i < N - 1) begin
                chk("done_early", done, 1'b0);
                chk("z_scan", Z, z_prev);
            end else begin
                chk("done_pulse", done, 1'b1);
                chk("busy_done", busy, 1'b1);
                chk("z_res", Z, ~e[1]);
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_off", done, 1'b0);
        chk("ready_post", ready, 1'b1);
        chk("x_hold", X, e[1]);
        chk("y_hold", Y, e[0]);
        chk("z_hold", Z, ~e[1]);
        z_prev = ~e[1];
    endtask

    initial begin
        int dq[$];
        int rdy_cnt[$];
        int rc;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        reset = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_x", X, 1'b0);
        chk("rst_y", Y, 1'b0);
        chk("rst_z", Z, 1'b1);
        chk("rst_zout", Z_out, 1'b1);
        reset = 1'b0;
        z_prev = 1'b1;

        op(8'h5A, 8'h5A, 1'b0);
        op(8'h80, 8'h7F, 1'b0);
        op(8'h01, 8'h02, 1'b0);
        op(8'h80, 8'h7F, 1'b1);

        // Reset during SCAN after bits 0..2
        @(negedge clk);
        start = 1'b1;
        A = 8'h80;
        B = 8'h7F;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_ready", ready, 1'b1);
        chk("mrst_x", X, 1'b0);
        chk("mrst_y", Y, 1'b0);
        chk("mrst_z", Z, 1'b1);
        chk("mrst_zout", Z_out, 1'b1);
        rc = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) rc++;
        end
        chk_int("mrst_nodone", rc, 0);
        z_prev = 1'b1;
        op(8'h03, 8'h01, 1'b0);

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1;
        A = 8'h3C;
        B = 8'hC3;
        rc = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (ready) rc++;
            if (done) begin
                dq.push_back(c);
                rdy_cnt.push_back(rc);
                rc = 0;
            end
        end
        start = 1'b0;
        chk_int("b2b_count", (dq.size() >= 3) ? 1 : 0, 1);
        for (int j = 1; j < dq.size(); j++) begin
            chk_int("b2b_period", dq[j] - dq[j-1], N + 2);
            chk_int("b2b_gap_ready", rdy_cnt[j], 1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        z_prev = 1'b1;

        // Random operands, biased toward near-equal values
        for (int r = 0; r < 20; r++) begin
            ra = N'($urandom);
            rb = (r % 2 == 0) ? (ra ^ N'(1 << $urandom_range(N - 1, 0)))
                              : N'($urandom);
            op(ra, rb, r % 5 == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
